// File: rtl/qimag_pkg.sv
// rtl/qimag_pkg.sv - shared quater-imaginary types and FSM states
package qimag_pkg;

  typedef logic [1:0] qdigit_t;

  localparam string QI_BASE_NOTE = "base 2i";

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } qstate_e;

endpackage

// File: rtl/qimag_horner_step.sv
// rtl/qimag_horner_step.sv - one MSB-first Horner step in base 2i
// (re, im, digit) -> (-2*im + digit, 2*re) with wrap to W bits and overflow flag.
module qimag_horner_step
  import qimag_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] i_re,
  input  logic signed [W-1:0] i_im,
  input  qdigit_t             i_digit,
  output logic signed [W-1:0] o_re,
  output logic signed [W-1:0] o_im,
  output logic                o_ovf
);

  logic signed [W+1:0] w_re_ext;
  logic signed [W+1:0] w_im_ext;
  logic signed [W+1:0] w_re_full;
  logic signed [W+1:0] w_im_full;

  assign w_re_ext  = {{2{i_re[W-1]}}, i_re};
  assign w_im_ext  = {{2{i_im[W-1]}}, i_im};
  assign w_re_full = -(w_im_ext <<< 1) + $signed({{W{1'b0}}, i_digit});
  assign w_im_full = w_re_ext <<< 1;

  assign o_re = w_re_full[W-1:0];
  assign o_im = w_im_full[W-1:0];

  // The W+2 value fits in W bits only when its top three bits agree.
  assign o_ovf = (w_re_full[W+1:W-1] != {3{w_re_full[W-1]}})
              | (w_im_full[W+1:W-1] != {3{w_im_full[W-1]}});

endmodule

// File: rtl/qimag_serial_decoder.sv
// rtl/qimag_serial_decoder.sv - serial base-2i digits to binary complex value
// Accumulates MSB-first digits in ACC, presents the result in HOLD until taken.
module qimag_serial_decoder
  import qimag_pkg::*;
#(
  parameter int NDIGITS = 8,
  parameter int W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_digit,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic                out_ovf,
  output logic                out_len
);

  localparam int CW = $clog2(NDIGITS + 1);

  qstate_e             r_state;
  qstate_e             w_state_next;
  logic signed [W-1:0] r_re;
  logic signed [W-1:0] r_im;
  logic                r_ovf;
  logic                r_len;
  logic [CW-1:0]       r_cnt;

  logic signed [W-1:0] w_re_next;
  logic signed [W-1:0] w_im_next;
  logic                w_step_ovf;
  logic                w_accept;
  logic                w_frame_end;
  logic                w_release;

  qimag_horner_step #(.W(W)) u_step (
    .i_re    (r_re),
    .i_im    (r_im),
    .i_digit (in_digit),
    .o_re    (w_re_next),
    .o_im    (w_im_next),
    .o_ovf   (w_step_ovf)
  );

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_frame_end  = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ACC: begin
        in_ready    = 1'b1;
        w_accept    = in_valid;
        w_frame_end = in_valid & (in_last | (r_cnt == CW'(NDIGITS - 1)));
        if (w_frame_end) w_state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_release    = 1'b1;
          w_state_next = ACC;
        end
      end
      default: w_state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACC;
      r_re    <= '0;
      r_im    <= '0;
      r_ovf   <= 1'b0;
      r_len   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_re  <= w_re_next;
        r_im  <= w_im_next;
        r_ovf <= r_ovf | w_step_ovf;
        r_cnt <= r_cnt + 1'b1;
        if (w_frame_end && !in_last) r_len <= 1'b1;
      end
      // Clearing on release means the next frame starts from re=im=0.
      if (w_release) begin
        r_re  <= '0;
        r_im  <= '0;
        r_ovf <= 1'b0;
        r_len <= 1'b0;
        r_cnt <= '0;
      end
    end
  end

  assign out_re  = r_re;
  assign out_im  = r_im;
  assign out_ovf = r_ovf;
  assign out_len = r_len;

endmodule

// File: tb/tb_qimag_serial_decoder.sv
// tb/tb_qimag_serial_decoder.sv - scoreboard bench for qimag_serial_decoder
module tb_qimag_serial_decoder;

  localparam int NDIG = 8;

  typedef struct {
    longint re;
    longint im;
    bit     ovf;
    bit     len;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf, a_out_len;
  logic [1:0]         a_in_digit;
  logic signed [15:0] a_out_re, a_out_im;
  logic               b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf, b_out_len;
  logic [1:0]         b_in_digit;
  logic signed [5:0]  b_out_re, b_out_im;

  qimag_serial_decoder #(.NDIGITS(NDIG), .W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_digit(a_in_digit), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_re(a_out_re), .out_im(a_out_im),
    .out_ovf(a_out_ovf), .out_len(a_out_len)
  );

  qimag_serial_decoder #(.NDIGITS(NDIG), .W(6)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_digit(b_in_digit), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_re(b_out_re), .out_im(b_out_im),
    .out_ovf(b_out_ovf), .out_len(b_out_len)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   fr[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Value of a digit string is sum(d_k * (2i)^k); every prefix is an intermediate result.
  function automatic exp_t model(input int d[$], input int w, input bit len);
    exp_t   e;
    longint lo, hi, pr, pi, mag, m, r;
    lo = -(64'sd1 <<< (w - 1));
    hi = -lo - 1;
    m  = 64'sd1 <<< w;
    e.ovf = 1'b0;
    pr = 0;
    pi = 0;
    for (int p = 1; p <= d.size(); p++) begin
      pr = 0;
      pi = 0;
      for (int j = 0; j < p; j++) begin
        int k;
        k   = p - 1 - j;
        mag = longint'(d[j]) <<< k;
        case (k % 4)
          0: pr += mag;
          1: pi += mag;
          2: pr -= mag;
          default: pi -= mag;
        endcase
      end
      if (pr < lo || pr > hi || pi < lo || pi > hi) e.ovf = 1'b1;
    end
    r = pr % m; if (r < 0) r += m; if (r > hi) r -= m; e.re = r;
    r = pi % m; if (r < 0) r += m; if (r > hi) r -= m; e.im = r;
    e.len = len;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_result: got re=%0d im=%0d expected none", a_out_re, a_out_im);
      end else begin
        e = qa.pop_front();
        check("a_re", a_out_re, e.re);
        check("a_im", a_out_im, e.im);
        check("a_ovf", a_out_ovf, longint'(e.ovf));
        check("a_len", a_out_len, longint'(e.len));
      end
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_result: got re=%0d im=%0d expected none", b_out_re, b_out_im);
      end else begin
        e = qb.pop_front();
        check("b_re", b_out_re, e.re);
        check("b_im", b_out_im, e.im);
        check("b_ovf", b_out_ovf, longint'(e.ovf));
        check("b_len", b_out_len, longint'(e.len));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      a_out_ready = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drive(input bit sel, input bit v, input logic [1:0] dg, input bit l);
    if (sel) begin
      b_in_valid = v; b_in_digit = dg; b_in_last = l;
    end else begin
      a_in_valid = v; a_in_digit = dg; a_in_last = l;
    end
  endtask

  // Sends fr[] to DUT a (sel=0) or b (sel=1); expectation is queued when the frame ends.
  task automatic send(input bit sel, input bit use_last, input int gap_max);
    int   n, t;
    bit   acc, ends, lst;
    exp_t e;
    int   pre[$];
    n = fr.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        drive(sel, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        tick();
      end
      lst  = use_last && (i == n - 1);
      ends = lst || (i == NDIG - 1);
      drive(sel, 1'b1, 2'(fr[i]), lst);
      if (ends) begin
        pre = fr[0:i];
        e = model(pre, sel ? 6 : 16, !lst);
        if (sel) qb.push_back(e); else qa.push_back(e);
      end
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = sel ? b_in_ready : a_in_ready;
        tick();
        t++;
      end
      if (!acc) begin
        checks++; failures++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
      end
      drive(sel, 1'b0, 2'd0, 1'b0);
      if (ends) check("valid_latency", sel ? b_out_valid : a_out_valid, 1);
    end
  endtask

  initial begin
    int n, t;
    bit ul;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_re", a_out_re, 0);
    check("rst_im", a_out_im, 0);
    check("rst_ovf", a_out_ovf, 0);
    check("rst_len", a_out_len, 0);
    rst = 1'b0;
    tick();

    fr = {1, 0, 3}; send(0, 1, 0);
    check("d103_re_const", a_out_re, -1);
    tick();
    fr = {1, 1};    send(0, 1, 1);
    fr = {1, 0};    send(0, 1, 1);
    fr = {2};       send(0, 1, 1);
    fr = {3, 0, 3, 0, 3}; send(1, 1, 0);
    check("w6_re_const", b_out_re, -25);
    check("w6_ovf_const", b_out_ovf, 1);
    tick();

    a_out_ready = 1'b0;
    fr = {0, 0, 0, 0, 0, 0, 0, 0}; send(0, 0, 0);
    drive(0, 1, 2'd1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("len_9th_in_ready", a_in_ready, 0);
      check("len_hold_valid", a_out_valid, 1);
      check("len_flag", a_out_len, 1);
      tick();
    end
    drive(0, 0, 0, 0);
    a_out_ready = 1'b1;
    tick();

    a_out_ready = 1'b0;
    fr = {1, 1}; send(0, 1, 0);
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", a_in_ready, 0);
      check("stall_valid", a_out_valid, 1);
      check("stall_re", a_out_re, 1);
      check("stall_im", a_out_im, 2);
      tick();
    end
    a_out_ready = 1'b1;
    tick();
    check("release_in_ready", a_in_ready, 1);
    check("release_valid", a_out_valid, 0);
    fr = {1, 0}; send(0, 1, 0);
    tick();

    fr = {3, 2, 1}; send(0, 0, 0);
    rst = 1'b1;
    #1;
    check("midrst_valid", a_out_valid, 0);
    check("midrst_in_ready", a_in_ready, 1);
    check("midrst_re", a_out_re, 0);
    tick();
    rst = 1'b0;
    fr = {2}; send(0, 1, 0);
    check("after_rst_re_const", a_out_re, 2);
    tick();

    rand_rdy = 1'b1;
    for (int f = 0; f < 55; f++) begin
      ul = 1'($urandom_range(0, 3) != 0);
      n  = ul ? $urandom_range(1, NDIG) : NDIG;
      fr = {};
      for (int i = 0; i < n; i++) fr.push_back($urandom_range(0, 3));
      send(f >= 40, ul, 3);
    end
    rand_rdy    = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin
      tick();
      t++;
    end
    check("drain_qa_empty", qa.size(), 0);
    check("drain_qb_empty", qb.size(), 0);
    tick();
    check("final_a_valid", a_out_valid, 0);
    check("final_b_valid", b_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
